jellyvl_synctimer_adjuster_dda: RTL and testbench

Divider-free successor to the synctimer adjuster driver. It spreads a signed timing-error request evenly over a requested cycle period with a DDA (Bresenham) accumulator, and emits one ±1 adjust pulse per accumulator overflow. It adds a pending-pulse queue behind the valid/ready handshake, carries the fractional remainder across same-sign updates, and flags overload. It sits between the synctimer error estimator (request side) and the local timer adjust input (adjust side).

---
 rtl/jellyvl_synctimer_pkg.sv | 45 ++++
 rtl/jellyvl_synctimer_adjuster_dda_if.sv | 37 +++
 rtl/jellyvl_synctimer_pending_counter.sv | 46 ++++
 rtl/jellyvl_synctimer_adjuster_dda.sv | 153 +++++++++++++++
 tb/tb_jellyvl_synctimer_adjuster_dda.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jellyvl_synctimer_pkg.sv
// Shared widths, aligned operand types and Q-alignment helpers
// for the synctimer adjust path.
package jellyvl_synctimer_pkg;

  localparam int DEF_CYCLE_WIDTH   = 32;
  localparam int DEF_CYCLE_Q       = 8;
  localparam int DEF_ERROR_WIDTH   = 32;
  localparam int DEF_ERROR_Q       = 8;
  localparam int DEF_PENDING_WIDTH = 4;

  function automatic int acc_q(
    input int cq,
    input int eq
  );
    return (cq > eq) ? cq : eq;
  endfunction

  localparam int DEF_ACC_Q =
    acc_q(DEF_CYCLE_Q, DEF_ERROR_Q);

  localparam int DEF_ERR_AW =
    DEF_ERROR_WIDTH + DEF_ACC_Q;
  localparam int DEF_CYC_AW =
    DEF_CYCLE_WIDTH + DEF_ACC_Q;
  localparam int DEF_ACC_W =
    ((DEF_ERR_AW > DEF_CYC_AW) ?
      DEF_ERR_AW : DEF_CYC_AW) + 1;

  typedef logic [DEF_ERR_AW-1:0] err_al_t;
  typedef logic [DEF_CYC_AW-1:0] cyc_al_t;
  typedef logic [DEF_ACC_W-1:0]  acc_t;

  localparam int ALIGN_W = 128;
  typedef logic [ALIGN_W-1:0] align_t;

  // Move a fixed-point value from q_from to q_to fraction bits.
  function automatic align_t align_q(
    input align_t v,
    input int     q_from,
    input int     q_to
  );
    return v << (q_to - q_from);
  endfunction

endpackage

// File: rtl/jellyvl_synctimer_adjuster_dda_if.sv
// Request (error estimator) and adjust (timer) handshake bundle
// for the DDA synctimer adjuster.
interface jellyvl_synctimer_adjuster_dda_if
  import jellyvl_synctimer_pkg::*;
#(
  parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH,
  parameter int CYCLE_Q     = DEF_CYCLE_Q,
  parameter int ERROR_WIDTH = DEF_ERROR_WIDTH,
  parameter int ERROR_Q     = DEF_ERROR_Q
) ();

  logic signed [ERROR_WIDTH+ERROR_Q-1:0] request_value;
  logic [CYCLE_WIDTH+CYCLE_Q-1:0]        request_cycle;
  logic                                  request_valid;
  logic                                  adjust_sign;
  logic                                  adjust_valid;
  logic                                  adjust_ready;

  modport master (
    output request_value,
    output request_cycle,
    output request_valid,
    output adjust_ready,
    input  adjust_sign,
    input  adjust_valid
  );

  modport slave (
    input  request_value,
    input  request_cycle,
    input  request_valid,
    input  adjust_ready,
    output adjust_sign,
    output adjust_valid
  );

endinterface

// File: rtl/jellyvl_synctimer_pending_counter.sv
// Saturating up/down pulse counter with a registered valid
// that mirrors count != 0.
module jellyvl_synctimer_pending_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inc,
  input  logic             ready,
  output logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             drop
);

  logic             take;
  logic             full;
  logic [WIDTH-1:0] count_next;

  assign take = valid & ready;
  assign full = &count;
  assign drop = inc & full & ~take;

  // Flush wins over a concurrent handshake.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (inc && !take && !full) begin
      count_next = count + WIDTH'(1);
    end else if (take && !inc) begin
      count_next = count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      valid <= 1'b0;
    end else begin
      count <= count_next;
      valid <= (count_next != '0);
    end
  end

endmodule

// File: rtl/jellyvl_synctimer_adjuster_dda.sv
// Spreads a signed timing error over a period with a DDA
// accumulator and queues one +/-1 adjust pulse per overflow.
module jellyvl_synctimer_adjuster_dda
  import jellyvl_synctimer_pkg::*;
#(
  parameter int CYCLE_WIDTH   = DEF_CYCLE_WIDTH,
  parameter int CYCLE_Q       = DEF_CYCLE_Q,
  parameter int ERROR_WIDTH   = DEF_ERROR_WIDTH,
  parameter int ERROR_Q       = DEF_ERROR_Q,
  parameter int PENDING_WIDTH = DEF_PENDING_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  jellyvl_synctimer_adjuster_dda_if.slave bus,
  output logic [PENDING_WIDTH-1:0] pending_count,
  output logic                     status_overrun,
  output logic                     status_param_error
);

  localparam int ACC_Q = acc_q(CYCLE_Q, ERROR_Q);
  localparam int VW    = ERROR_WIDTH + ERROR_Q;
  localparam int EW    = ERROR_WIDTH + ACC_Q;
  localparam int CW    = CYCLE_WIDTH + ACC_Q;
  localparam int AW    = ((EW > CW) ? EW : CW) + 1;

  logic [VW-1:0] value;
  logic [VW-1:0] most_neg;
  logic [VW-1:0] mag;
  logic          neg;
  logic [EW-1:0] err_al;
  logic [CW-1:0] cyc_al;
  logic          cyc_zero;

  assign value    = bus.request_value;
  assign neg      = value[VW-1];
  assign most_neg = {1'b1, {(VW-1){1'b0}}};
  assign cyc_zero = (bus.request_cycle == '0);

  // The most negative input has no positive twin; saturate it.
  always_comb begin
    mag = value;
    if (neg) begin
      mag = (value == most_neg) ? ~most_neg : -value;
    end
  end

  assign err_al = EW'(align_q(align_t'(mag),
                              ERROR_Q, ACC_Q));
  assign cyc_al = CW'(align_q(align_t'(bus.request_cycle),
                              CYCLE_Q, ACC_Q));

  logic          r_valid;
  logic          r_sign;
  logic [EW-1:0] r_err;
  logic [CW-1:0] r_cyc;

  logic          act_sign;
  logic [EW-1:0] act_err;
  logic [CW-1:0] act_cyc;
  logic [AW-1:0] acc;

  logic [AW-1:0] sum;
  logic [AW-1:0] diff;
  logic [AW-1:0] cyc_ext;
  logic [AW-1:0] r_cyc_ext;
  logic          run;
  logic          hit;
  logic          over;
  logic          flush;
  logic          drop;

  assign cyc_ext   = AW'(act_cyc);
  assign r_cyc_ext = AW'(r_cyc);
  assign sum       = acc + AW'(act_err);
  assign diff      = sum - cyc_ext;
  assign run       = (act_err != '0) && !r_valid;
  assign hit       = run && (sum >= cyc_ext);
  assign over      = hit && (diff >= cyc_ext);

  // A sign change or zero request drops every queued pulse.
  assign flush = r_valid &&
                 ((r_sign != act_sign) || (r_err == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid            <= 1'b0;
      r_sign             <= 1'b0;
      r_err              <= '0;
      r_cyc              <= '0;
      act_sign           <= 1'b0;
      act_err            <= '0;
      act_cyc            <= '0;
      acc                <= '0;
      status_overrun     <= 1'b0;
      status_param_error <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (r_valid) begin
        act_sign           <= r_sign;
        act_err            <= r_err;
        act_cyc            <= r_cyc;
        status_overrun     <= 1'b0;
        status_param_error <= 1'b0;
        if (flush) begin
          acc <= '0;
        end else if (acc >= r_cyc_ext) begin
          acc <= r_cyc_ext - AW'(1);
        end
      end else if (run) begin
        if (over) begin
          acc            <= cyc_ext - AW'(1);
          status_overrun <= 1'b1;
        end else if (hit) begin
          acc <= diff;
        end else begin
          acc <= sum;
        end
      end

      if (drop) begin
        status_overrun <= 1'b1;
      end

      if (bus.request_valid) begin
        if (cyc_zero) begin
          status_param_error <= 1'b1;
        end else begin
          r_valid <= 1'b1;
          r_sign  <= neg;
          r_err   <= err_al;
          r_cyc   <= cyc_al;
        end
      end
    end
  end

  assign bus.adjust_sign = act_sign;

  jellyvl_synctimer_pending_counter #(
    .WIDTH (PENDING_WIDTH)
  ) u_pending (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .inc   (hit),
    .ready (bus.adjust_ready),
    .count (pending_count),
    .valid (bus.adjust_valid),
    .drop  (drop)
  );

endmodule

// File: tb/tb_jellyvl_synctimer_adjuster_dda.sv
// Directed test-plan scenarios plus random traffic against a
// queue-based behavioural model of the adjuster.
module tb_jellyvl_synctimer_adjuster_dda;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pending_count;
  logic       status_overrun;
  logic       status_param_error;

  always #5 clk = ~clk;

  jellyvl_synctimer_adjuster_dda_if bus ();

  jellyvl_synctimer_adjuster_dda dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .pending_count      (pending_count),
    .status_overrun     (status_overrun),
    .status_param_error (status_param_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(
    input string           tag,
    input longint unsigned got,
    input longint unsigned exp
  );
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Behavioural model: pending pulses are a queue of signs.
  localparam longint unsigned MAXM = 64'h7F_FFFF_FFFF;
  localparam int              QMAX = 15;

  bit              rq_v, rq_s;
  longint unsigned rq_m, rq_c;
  bit              m_sign, m_ovr, m_perr;
  longint unsigned m_err, m_cyc, m_acc;
  bit              m_q[$];

  task automatic model_step();
    bit              took, pulse;
    longint          sv;
    longint unsigned s;
    if (reset) begin
      rq_v = 0; m_sign = 0; m_err = 0; m_cyc = 0;
      m_acc = 0; m_ovr = 0; m_perr = 0;
      m_q.delete();
      return;
    end
    took  = (m_q.size() != 0) && bus.adjust_ready;
    pulse = 0;
    if (rq_v) begin
      if (rq_s != m_sign || rq_m == 0) begin
        m_q.delete();
        took  = 0;
        m_acc = 0;
      end else if (m_acc >= rq_c) begin
        m_acc = rq_c - 1;
      end
      m_sign = rq_s; m_err = rq_m; m_cyc = rq_c;
      m_ovr = 0; m_perr = 0;
    end else if (m_err != 0) begin
      s = m_acc + m_err;
      if (s >= m_cyc) begin
        pulse = 1;
        s = s - m_cyc;
        if (s >= m_cyc) begin
          m_ovr = 1;
          s = m_cyc - 1;
        end
      end
      m_acc = s;
    end
    if (took) void'(m_q.pop_front());
    if (pulse) begin
      if (m_q.size() < QMAX) m_q.push_back(m_sign);
      else m_ovr = 1;
    end
    rq_v = 0;
    if (bus.request_valid) begin
      if (bus.request_cycle == 0) begin
        m_perr = 1;
      end else begin
        sv   = longint'(bus.request_value);
        rq_v = 1;
        rq_s = (sv < 0);
        rq_m = (sv < 0) ? longint'(-sv) : sv;
        if (rq_m > MAXM) rq_m = MAXM;
        rq_c = bus.request_cycle;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("m_valid", bus.adjust_valid, m_q.size() != 0);
    chk("m_pend", pending_count, m_q.size());
    chk("m_ovr", status_overrun, m_ovr);
    chk("m_perr", status_param_error, m_perr);
    if (m_q.size() != 0) chk("m_sign", bus.adjust_sign, m_q[0]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.request_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input longint v, input longint c);
    bus.request_value = 40'(v);
    bus.request_cycle = 40'(c);
    bus.request_valid = 1'b1;
    tick();
    bus.request_valid = 1'b0;
  endtask

  int     cnt, maxp, first, found;
  int     s1_e[$];
  int     s1_exp[3] = '{335, 668, 1001};
  longint v, c;
  bit     sg;

  initial begin
    bus.request_value = '0;
    bus.request_cycle = '0;
    bus.request_valid = 1'b0;
    bus.adjust_ready  = 1'b0;
    do_reset();
    chk("rst_valid", bus.adjust_valid, 0);
    chk("rst_pend", pending_count, 0);
    chk("rst_sign", bus.adjust_sign, 0);
    chk("rst_ovr", status_overrun, 0);
    chk("rst_perr", status_param_error, 0);

    // Basic spacing: +3.0 over 1000.0
    bus.adjust_ready = 1'b1;
    set_req(64'h300, 1000 << 8);
    maxp = 0;
    for (int e = 1; e <= 1100; e++) begin
      tick();
      if (bus.adjust_valid) begin
        s1_e.push_back(e);
        chk("s1_sign", bus.adjust_sign, 0);
      end
      if (int'(pending_count) > maxp) maxp = pending_count;
    end
    chk("s1_n", s1_e.size(), 3);
    for (int i = 0; i < s1_e.size() && i < 3; i++)
      chk("s1_edge", s1_e[i], s1_exp[i]);
    chk("s1_maxp", maxp, 1);

    // Reset mid-run with a pulse pending
    do_reset();
    bus.adjust_ready = 1'b0;
    set_req(64'h300, 1000 << 8);
    found = 0;
    for (int e = 1; e <= 400; e++) begin
      tick();
      if (pending_count == 1) begin
        found = 1;
        break;
      end
    end
    chk("s6_found", found, 1);
    reset = 1'b1;
    tick();
    chk("s6_valid", bus.adjust_valid, 0);
    chk("s6_pend", pending_count, 0);
    chk("s6_sign", bus.adjust_sign, 0);
    reset = 1'b0;
    bus.adjust_ready = 1'b1;
    cnt = 0;
    for (int e = 0; e < 1200; e++) begin
      tick();
      if (bus.adjust_valid) cnt++;
    end
    chk("s6_quiet", cnt, 0);

    // Negative, then sign change flushes
    do_reset();
    bus.adjust_ready = 1'b0;
    set_req(-64'sd640, 100 << 8);
    for (int e = 1; e <= 100; e++) tick();
    chk("s2_pend", pending_count, 2);
    chk("s2_sign", bus.adjust_sign, 1);
    set_req(64'h100, 100 << 8);
    tick();
    chk("s2_flush", pending_count, 0);
    chk("s2_fvalid", bus.adjust_valid, 0);
    bus.adjust_ready = 1'b1;
    first = -1;
    for (int e = 2; e <= 300; e++) begin
      tick();
      if (bus.adjust_valid) begin
        first = e;
        chk("s2_psign", bus.adjust_sign, 0);
        break;
      end
    end
    chk("s2_first", first, 101);

    // Remainder carry across same-sign updates
    do_reset();
    bus.adjust_ready  = 1'b1;
    bus.request_value = 40'h180;
    bus.request_cycle = 40'(10 << 8);
    cnt = 0;
    for (int e = 0; e <= 22; e++) begin
      bus.request_valid = (e == 0) || (e == 6);
      tick();
      if (bus.adjust_valid) cnt++;
    end
    bus.request_valid = 1'b0;
    chk("s3_n", cnt, 3);

    // Backpressure and overload
    do_reset();
    bus.adjust_ready = 1'b0;
    set_req(20 << 8, 10 << 8);
    repeat (30) tick();
    chk("s4_pend", pending_count, 15);
    chk("s4_ovr", status_overrun, 1);
    bus.adjust_ready = 1'b1;
    cnt = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (bus.adjust_valid) cnt++;
    end
    chk("s4_thru", cnt, 10);
    chk("s4_hold", pending_count, 15);
    set_req(0, 10 << 8);
    tick();
    chk("s4_zpend", pending_count, 0);
    chk("s4_zovr", status_overrun, 0);
    cnt = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (bus.adjust_valid) cnt++;
    end
    chk("s4_zquiet", cnt, 0);

    // Zero cycle is rejected, old parameters keep running
    do_reset();
    bus.adjust_ready = 1'b1;
    set_req(64'h100, 10 << 8);
    repeat (20) tick();
    set_req(64'h100, 0);
    chk("s5_perr", status_param_error, 1);
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (bus.adjust_valid) cnt++;
    end
    chk("s5_cont", cnt, 4);
    chk("s5_sticky", status_param_error, 1);
    set_req(64'h100, 10 << 8);
    tick();
    chk("s5_clear", status_param_error, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.adjust_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 499) == 0);
      bus.request_valid = 1'b0;
      if (!reset && $urandom_range(0, 29) == 0) begin
        sg = 1'($urandom_range(0, 1));
        v  = longint'($urandom_range(0, 2048));
        if ($urandom_range(0, 9) == 0) v = 0;
        if (sg) v = -v;
        if ($urandom_range(0, 19) == 0)
          v = -64'sh80_0000_0000;
        c = longint'($urandom_range(64, 8192));
        if ($urandom_range(0, 15) == 0) c = 0;
        bus.request_value = 40'(v);
        bus.request_cycle = 40'(c);
        bus.request_valid = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    bus.request_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
